// File: rtl/produto_escalar_stream.sv
// produto_escalar_stream: streaming dot product with a registered multiply stage
// followed by a wrapping accumulator and a sticky overflow flag.
module produto_escalar_stream #(
    parameter int DATA_W = 32,
    parameter int LEN    = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(LEN) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     iniciar,
    input  logic                     abortar,
    input  logic [$clog2(LEN+1)-1:0] comprimento,
    input  logic                     modo_sinal,
    input  logic [DATA_W-1:0]        a_i,
    input  logic [DATA_W-1:0]        b_i,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     ocupado,
    output logic                     concluido,
    output logic [ACC_W-1:0]         resultado,
    output logic                     estouro
);
    localparam int CW = $clog2(LEN+1);
    localparam int PW = 2*DATA_W;

    typedef enum logic [1:0] {PARADO, CALCULANDO, ESVAZIANDO, FEITO} estado_t;

    estado_t           estado_q;
    logic [CW-1:0]     len_q, cnt_q, len_d;
    logic              sinal_q, prod_vld_q, estouro_q;
    logic [PW-1:0]     prod_q, prod_d;
    logic [ACC_W-1:0]  acc_q, prod_sx, prod_ext;
    logic [ACC_W:0]    soma;
    logic              aceita, ovf;

    always_comb begin
        len_d    = (comprimento > CW'(LEN)) ? CW'(LEN) : comprimento;
        aceita   = (estado_q == CALCULANDO) && in_valid;
        // Operands are extended per mode so one 2W-bit multiplier serves both modes.
        prod_d   = {{DATA_W{sinal_q & a_i[DATA_W-1]}}, a_i} * {{DATA_W{sinal_q & b_i[DATA_W-1]}}, b_i};
        prod_sx  = ACC_W'($signed(prod_q));
        prod_ext = sinal_q ? prod_sx : ACC_W'(prod_q);
        soma     = {1'b0, acc_q} + {1'b0, prod_ext};
        ovf      = sinal_q ? (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (soma[ACC_W-1] != acc_q[ACC_W-1])
                           : soma[ACC_W];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            estado_q   <= PARADO;
            len_q      <= '0;
            cnt_q      <= '0;
            sinal_q    <= 1'b0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            estouro_q  <= 1'b0;
        end else if (abortar) begin
            estado_q   <= PARADO;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            estouro_q  <= 1'b0;
        end else begin
            prod_vld_q <= aceita;
            if (aceita)
                prod_q <= prod_d;
            if (prod_vld_q) begin
                acc_q <= soma[ACC_W-1:0];
                if (ovf)
                    estouro_q <= 1'b1;
            end
            case (estado_q)
                PARADO: if (iniciar) begin
                    len_q     <= len_d;
                    sinal_q   <= modo_sinal;
                    cnt_q     <= '0;
                    acc_q     <= '0;
                    estouro_q <= 1'b0;
                    estado_q  <= (len_d == '0) ? FEITO : CALCULANDO;
                end
                CALCULANDO: if (in_valid) begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == len_q - CW'(1))
                        estado_q <= ESVAZIANDO;
                end
                ESVAZIANDO: estado_q <= FEITO;
                FEITO: if (!iniciar)
                    estado_q <= PARADO;
                default: estado_q <= PARADO;
            endcase
        end
    end

    assign in_ready  = estado_q == CALCULANDO;
    assign ocupado   = (estado_q == CALCULANDO) || (estado_q == ESVAZIANDO);
    assign concluido = estado_q == FEITO;
    assign resultado = acc_q;
    assign estouro   = estouro_q;
endmodule

// File: tb/tb_produto_escalar_stream.sv
// tb_produto_escalar_stream: scenario tasks drive operations; expected results go
// through a scoreboard queue and are compared when concluido rises.
module tb_produto_escalar_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, iniciar, abortar, modo_sinal, in_valid;
    logic [3:0]  comprimento;
    logic [31:0] a_i, b_i;
    logic        in_ready, ocupado, concluido, estouro;
    logic        in_ready2, ocupado2, concluido2, estouro2;
    logic [67:0] resultado;
    logic [63:0] resultado2;

    produto_escalar_stream dut (
        .clk_i(clk), .rst_i(rst_i), .iniciar(iniciar), .abortar(abortar),
        .comprimento(comprimento), .modo_sinal(modo_sinal), .a_i(a_i), .b_i(b_i),
        .in_valid(in_valid), .in_ready(in_ready), .ocupado(ocupado),
        .concluido(concluido), .resultado(resultado), .estouro(estouro)
    );

    produto_escalar_stream #(.ACC_W(64)) dut64 (
        .clk_i(clk), .rst_i(rst_i), .iniciar(iniciar), .abortar(abortar),
        .comprimento(comprimento), .modo_sinal(modo_sinal), .a_i(a_i), .b_i(b_i),
        .in_valid(in_valid), .in_ready(in_ready2), .ocupado(ocupado2),
        .concluido(concluido2), .resultado(resultado2), .estouro(estouro2)
    );

    typedef struct packed {
        logic [67:0] r;
        logic        o;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] av[12], bv[12];
    int          ec = 0;
    int          n_chk = 0, n_fail = 0;

    always @(posedge clk) ec <= ec + 1;

    // Independent reference: exact arithmetic with range checks, then wrap to accw bits.
    function automatic void model(input int n, input bit sg, input int accw,
                                  output logic [67:0] r, output bit o);
        logic signed [127:0] w, t, p, lo, hi, m, one;
        one = 128'sd1;
        w = '0;
        o = 1'b0;
        lo = sg ? -(one <<< (accw-1)) : '0;
        hi = sg ? (one <<< (accw-1)) - one : (one <<< accw) - one;
        for (int i = 0; i < n; i++) begin
            if (sg) p = $signed({{96{av[i][31]}}, av[i]}) * $signed({{96{bv[i][31]}}, bv[i]});
            else    p = $signed({96'b0, av[i]}) * $signed({96'b0, bv[i]});
            t = w + p;
            if (t < lo || t > hi) o = 1'b1;
            m = t & ((one <<< accw) - one);
            if (sg && m[accw-1]) m = m - (one <<< accw);
            w = m;
        end
        m = w & ((one <<< accw) - one);
        r = m[67:0];
    endfunction

    task automatic drive_op(input int n, input bit sg, input bit tog, input bit sel,
                            output int nacc, output int lat, output logic [67:0] res,
                            output bit ovf, output bit ok, output bit conc_after,
                            output logic [67:0] res_after);
        int  last;
        bit  ph;
        nacc = 0; last = 0; ok = 1'b0; ph = 1'b1; lat = 0;
        @(negedge clk);
        iniciar = 1'b1; comprimento = n[3:0]; modo_sinal = sg; in_valid = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (sel ? concluido2 : concluido) begin
                ok = 1'b1;
                break;
            end
            in_valid = tog ? ph : 1'b1;
            ph = !ph;
            a_i = av[nacc % 12];
            b_i = bv[nacc % 12];
            if (in_ready && in_valid) begin
                nacc++;
                last = ec + 1;
            end
        end
        in_valid = 1'b0;
        lat = ec - last + 1;
        res = sel ? {4'b0, resultado2} : resultado;
        ovf = sel ? estouro2 : estouro;
        iniciar = 1'b0;
        @(negedge clk);
        conc_after = sel ? concluido2 : concluido;
        res_after = sel ? {4'b0, resultado2} : resultado;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; iniciar = 1'b0; abortar = 1'b0; modo_sinal = 1'b0;
        in_valid = 1'b0; comprimento = '0; a_i = '0; b_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
        n_chk++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL reset ocupado: got %b expected 0", ocupado); end
        n_chk++; if (concluido !== 1'b0) begin n_fail++; $display("FAIL reset concluido: got %b expected 0", concluido); end
        n_chk++; if (resultado !== 68'h0) begin n_fail++; $display("FAIL reset resultado: got %0h expected 0", resultado); end
        n_chk++; if (estouro !== 1'b0) begin n_fail++; $display("FAIL reset estouro: got %b expected 0", estouro); end
        rst_i = 1'b0;
    endtask

    task automatic test_sequence();
        int nacc, lat; logic [67:0] res, ra; bit ovf, ok, ca;
        for (int i = 0; i < 8; i++) begin av[i] = i + 1; bv[i] = 1; end
        sb.push_back({68'd36, 1'b0});
        drive_op(8, 1'b1, 1'b0, 1'b0, nacc, lat, res, ovf, ok, ca, ra);
        e = sb.pop_front();
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL seq timeout: got %b expected 1", ok); end
        n_chk++; if (nacc != 8) begin n_fail++; $display("FAIL seq accepts: got %0d expected 8", nacc); end
        n_chk++; if (lat != 2) begin n_fail++; $display("FAIL seq latency: got %0d expected 2", lat); end
        n_chk++; if (res !== e.r) begin n_fail++; $display("FAIL seq resultado: got %0h expected %0h", res, e.r); end
        n_chk++; if (ovf !== e.o) begin n_fail++; $display("FAIL seq estouro: got %b expected %b", ovf, e.o); end
        n_chk++; if (ca !== 1'b0) begin n_fail++; $display("FAIL seq concluido after drop: got %b expected 0", ca); end
        n_chk++; if (ra !== e.r) begin n_fail++; $display("FAIL seq resultado held: got %0h expected %0h", ra, e.r); end
    endtask

    task automatic test_stall();
        int nacc, lat; logic [67:0] res, ra; bit ovf, ok, ca;
        av[0] = -32'sd1; av[1] = -32'sd2; av[2] = 32'sd3;
        bv[0] = 32'sd5;  bv[1] = 32'sd5;  bv[2] = -32'sd4;
        sb.push_back({68'hF_FFFF_FFFF_FFFF_FFE5, 1'b0});
        drive_op(3, 1'b1, 1'b1, 1'b0, nacc, lat, res, ovf, ok, ca, ra);
        e = sb.pop_front();
        n_chk++; if (nacc != 3) begin n_fail++; $display("FAIL stall accepts: got %0d expected 3", nacc); end
        n_chk++; if (res !== e.r) begin n_fail++; $display("FAIL stall resultado: got %0h expected %0h", res, e.r); end
        n_chk++; if (ovf !== e.o) begin n_fail++; $display("FAIL stall estouro: got %b expected %b", ovf, e.o); end
        n_chk++; if (lat != 2) begin n_fail++; $display("FAIL stall latency: got %0d expected 2", lat); end
    endtask

    task automatic test_unsigned();
        int nacc, lat; logic [67:0] res, ra; bit ovf, ok, ca;
        av[0] = 32'hFFFF_FFFF; av[1] = 32'hFFFF_FFFF;
        bv[0] = 32'hFFFF_FFFF; bv[1] = 32'hFFFF_FFFF;
        sb.push_back({68'h1_FFFF_FFFC_0000_0002, 1'b0});
        drive_op(2, 1'b0, 1'b0, 1'b0, nacc, lat, res, ovf, ok, ca, ra);
        e = sb.pop_front();
        n_chk++; if (res !== e.r) begin n_fail++; $display("FAIL unsigned resultado: got %0h expected %0h", res, e.r); end
        n_chk++; if (ovf !== e.o) begin n_fail++; $display("FAIL unsigned estouro: got %b expected %b", ovf, e.o); end
    endtask

    task automatic test_overflow();
        int nacc, lat; logic [67:0] res, ra; bit ovf, ok, ca;
        av[0] = 32'h8000_0000; av[1] = 32'h8000_0000;
        bv[0] = 32'h8000_0000; bv[1] = 32'h8000_0000;
        sb.push_back({68'h0_8000_0000_0000_0000, 1'b1});
        drive_op(2, 1'b1, 1'b0, 1'b1, nacc, lat, res, ovf, ok, ca, ra);
        e = sb.pop_front();
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ovf timeout: got %b expected 1", ok); end
        n_chk++; if (res !== e.r) begin n_fail++; $display("FAIL ovf resultado: got %0h expected %0h", res, e.r); end
        n_chk++; if (ovf !== e.o) begin n_fail++; $display("FAIL ovf estouro: got %b expected %b", ovf, e.o); end
    endtask

    task automatic test_zero_length();
        @(negedge clk);
        iniciar = 1'b1; comprimento = 4'd0; modo_sinal = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_chk++; if (concluido !== 1'b1) begin n_fail++; $display("FAIL zero concluido: got %b expected 1", concluido); end
        n_chk++; if (resultado !== 68'h0) begin n_fail++; $display("FAIL zero resultado: got %0h expected 0", resultado); end
        n_chk++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL zero ocupado: got %b expected 0", ocupado); end
        iniciar = 1'b0;
        @(negedge clk);
        n_chk++; if (concluido !== 1'b0) begin n_fail++; $display("FAIL zero concluido after drop: got %b expected 0", concluido); end
    endtask

    task automatic test_clamp();
        int nacc, lat; logic [67:0] res, ra; bit ovf, ok, ca;
        for (int i = 0; i < 12; i++) begin av[i] = i + 1; bv[i] = 2; end
        sb.push_back({68'd72, 1'b0});
        drive_op(12, 1'b0, 1'b0, 1'b0, nacc, lat, res, ovf, ok, ca, ra);
        e = sb.pop_front();
        n_chk++; if (nacc != 8) begin n_fail++; $display("FAIL clamp accepts: got %0d expected 8", nacc); end
        n_chk++; if (res !== e.r) begin n_fail++; $display("FAIL clamp resultado: got %0h expected %0h", res, e.r); end
    endtask

    task automatic test_abort_reset(input bit use_rst);
        int cnt, nacc, lat; logic [67:0] res, ra; bit ovf, ok, ca;
        for (int i = 0; i < 8; i++) begin av[i] = i + 1; bv[i] = 1; end
        @(negedge clk);
        iniciar = 1'b1; comprimento = 4'd8; modo_sinal = 1'b1;
        @(posedge clk);
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 4; c++) begin
            @(negedge clk);
            in_valid = 1'b1; a_i = av[cnt]; b_i = bv[cnt];
            if (in_ready) cnt++;
        end
        @(negedge clk);
        in_valid = 1'b0; iniciar = 1'b0;
        if (use_rst) rst_i = 1'b1; else abortar = 1'b1;
        @(negedge clk);
        n_chk++; if (cnt != 4) begin n_fail++; $display("FAIL abort%0d accepts before stop: got %0d expected 4", use_rst, cnt); end
        n_chk++; if (concluido !== 1'b0) begin n_fail++; $display("FAIL abort%0d concluido: got %b expected 0", use_rst, concluido); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort%0d in_ready: got %b expected 0", use_rst, in_ready); end
        n_chk++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL abort%0d ocupado: got %b expected 0", use_rst, ocupado); end
        n_chk++; if (resultado !== 68'h0) begin n_fail++; $display("FAIL abort%0d resultado: got %0h expected 0", use_rst, resultado); end
        rst_i = 1'b0; abortar = 1'b0;
        sb.push_back({68'd36, 1'b0});
        drive_op(8, 1'b1, 1'b0, 1'b0, nacc, lat, res, ovf, ok, ca, ra);
        e = sb.pop_front();
        n_chk++; if (res !== e.r) begin n_fail++; $display("FAIL abort%0d restart resultado: got %0h expected %0h", use_rst, res, e.r); end
        n_chk++; if (nacc != 8) begin n_fail++; $display("FAIL abort%0d restart accepts: got %0d expected 8", use_rst, nacc); end
    endtask

    task automatic test_back_to_back();
        int n, nacc, lat; bit sg; logic [67:0] res, ra, r; bit ovf, ok, ca, o;
        for (int k = 0; k < 5; k++) begin
            n = $urandom_range(1, 8);
            sg = 1'(k % 2);
            for (int i = 0; i < 8; i++) begin
                av[i] = (k == 4) ? 32'h7FFF_FFFF : $urandom;
                bv[i] = (k == 4) ? 32'h7FFF_FFFF : $urandom;
            end
            model(n, sg, 68, r, o);
            sb.push_back({r, o});
            drive_op(n, sg, 1'($urandom % 2), 1'b0, nacc, lat, res, ovf, ok, ca, ra);
            e = sb.pop_front();
            n_chk++; if (nacc != n) begin n_fail++; $display("FAIL b2b%0d accepts: got %0d expected %0d", k, nacc, n); end
            n_chk++; if (res !== e.r) begin n_fail++; $display("FAIL b2b%0d resultado: got %0h expected %0h", k, res, e.r); end
            n_chk++; if (ovf !== e.o) begin n_fail++; $display("FAIL b2b%0d estouro: got %b expected %b", k, ovf, e.o); end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_unsigned();
        test_zero_length();
        test_overflow();
        test_clamp();
        test_abort_reset(1'b0);
        test_abort_reset(1'b1);
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
